// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, owner encoding and
// the word-index / range-check helpers used when a request is captured.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

    function automatic logic in_range(input logic [63:0] byte_addr, input logic [63:0] words);
        return word_index(byte_addr) < words;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: among the unmasked requesters, a tie goes to the master
// that did not win last time.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic [1:0] mask,
    output logic       gnt_valid,
    output owner_t     gnt_id
);
    logic [1:0] cand;

    always_comb begin
        cand      = req & mask;
        gnt_valid = |cand;
        gnt_id    = OWN_M0;
        if (cand == 2'b11) begin
            gnt_id = (last == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (cand[1]) begin
            gnt_id = OWN_M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU data port (m0) and the DMA/debug
// loader (m1). Each transaction: request sampled in IDLE, access in ACCESS, ack in RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MEM_WORDS = 65536,
    parameter int LOCK_MAX  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t        state;
    owner_t        owner, last_grant, lock_owner, gnt_id;
    logic          gnt_valid, lock_held, lock_expired, lock_active, owner_req;
    logic [CW-1:0] lock_cnt;
    logic [1:0]    mask;
    logic [AW-1:0] reg_addr, sel_addr;
    logic [DW-1:0] reg_wdata, sel_wdata, captured;
    logic          reg_we, reg_lock, reg_inr, sel_we, sel_lock;

    // An expiring lock is dropped in the same IDLE cycle, so the other master can win right away.
    assign owner_req    = (lock_owner == OWN_M1) ? m1_req : m0_req;
    assign lock_expired = lock_held && !owner_req && (lock_cnt == CW'(LOCK_MAX));
    assign lock_active  = lock_held && !lock_expired;
    assign mask         = lock_active ? ((lock_owner == OWN_M1) ? 2'b10 : 2'b01) : 2'b11;

    rr_arb2 u_rr (
        .req       ({m1_req, m0_req}),
        .last      (last_grant),
        .mask      (mask),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_addr  = (gnt_id == OWN_M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (gnt_id == OWN_M1) ? m1_wdata : m0_wdata;
    assign sel_we    = (gnt_id == OWN_M1) ? m1_we    : m0_we;
    assign sel_lock  = (gnt_id == OWN_M1) ? m1_lock  : m0_lock;

    assign mem_addr  = reg_addr;
    assign mem_wdata = reg_wdata;
    assign mem_we    = (state == ACCESS) && reg_we && reg_inr;
    assign captured  = (!reg_we && reg_inr) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_M0;
            last_grant <= OWN_M1;
            lock_owner <= OWN_M0;
            lock_held  <= 1'b0;
            lock_cnt   <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_lock   <= 1'b0;
            reg_inr    <= 1'b0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_expired) begin
                        lock_held <= 1'b0;
                        lock_cnt  <= '0;
                    end else if (lock_held && !owner_req) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                    if (gnt_valid) begin
                        owner      <= gnt_id;
                        last_grant <= gnt_id;
                        reg_addr   <= sel_addr;
                        reg_wdata  <= sel_wdata;
                        reg_we     <= sel_we;
                        reg_lock   <= sel_lock;
                        reg_inr    <= in_range(64'(sel_addr), 64'(MEM_WORDS));
                        state      <= ACCESS;
                        if (lock_held && gnt_id == lock_owner) lock_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (owner == OWN_M1) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= !reg_inr;
                        m1_rdata <= captured;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= !reg_inr;
                        m0_rdata <= captured;
                    end
                    state <= RESP;
                end
                RESP: begin
                    lock_held  <= reg_lock;
                    lock_owner <= owner;
                    lock_cnt   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// from both masters against a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;
    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int MEM_WORDS = 65536;
    localparam int LOCK_MAX  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    req_s  = 2'b00;
    logic [1:0]    we_s   = 2'b00;
    logic [1:0]    lock_s = 2'b00;
    logic [31:0]   addr_s [2];
    logic [31:0]   wdata_s[2];
    logic          m0_ack, m0_err, m1_ack, m1_err, mem_we;
    logic [31:0]   m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0]   mem [0:MEM_WORDS-1];
    assign mem_rdata = mem[mem_addr[17:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[17:2]] <= mem_wdata;

    dmem_arbiter #(.DW(DW), .AW(AW), .MEM_WORDS(MEM_WORDS), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req_s[0]), .m0_we(we_s[0]), .m0_lock(lock_s[0]), .m0_addr(addr_s[0]),
        .m0_wdata(wdata_s[0]), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req_s[1]), .m1_we(we_s[1]), .m1_lock(lock_s[1]), .m1_addr(addr_s[1]),
        .m1_wdata(wdata_s[1]), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: a transaction occupies three cycles from its grant cycle g
    // (g: grant, g+1: memory access, g+2: ack); the arbiter is free again from g+3.
    logic [31:0] ref_mem [int unsigned];
    int          cyc = 0;
    bit          busy = 0;
    int          g = 0, tm = 0, lk = -1, idle = 0, last = 1;
    logic        t_we, t_lock, t_inr;
    logic [31:0] t_addr, t_wdata;
    int unsigned t_word;
    logic [1:0]  e_ack = 2'b00, e_err = 2'b00;
    logic        e_mem_we = 1'b0, e_access = 1'b0;
    logic [31:0] e_rdata[2] = '{32'h0, 32'h0};
    bit          pend[2] = '{0, 0};

    function automatic logic [31:0] rd_ref(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic model_reset();
        busy = 0; lk = -1; idle = 0; last = 1;
        e_ack = 2'b00; e_err = 2'b00; e_mem_we = 1'b0; e_access = 1'b0;
        e_rdata[0] = 32'h0; e_rdata[1] = 32'h0; pend[0] = 0; pend[1] = 0;
    endtask

    task automatic arbitrate();
        bit c0, c1;
        int m;
        if (lk >= 0 && !req_s[lk]) begin
            if (idle == LOCK_MAX) begin
                lk = -1; idle = 0;
            end else begin
                idle++;
                return;
            end
        end
        c0 = req_s[0] && (lk < 0 || lk == 0);
        c1 = req_s[1] && (lk < 0 || lk == 1);
        if (!c0 && !c1) return;
        m = (c0 && c1) ? 1 - last : (c1 ? 1 : 0);
        if (lk == m) idle = 0;
        busy = 1; g = cyc; tm = m; last = m; pend[m] = 1;
        t_we = we_s[m]; t_lock = lock_s[m]; t_addr = addr_s[m]; t_wdata = wdata_s[m];
        t_word = t_addr >> 2;
        t_inr  = (t_word < MEM_WORDS);
    endtask

    task automatic model_step();
        cyc++;
        e_access = 1'b0; e_mem_we = 1'b0; e_ack = 2'b00; e_err = 2'b00;
        if (busy && cyc == g + 1) begin
            e_access = 1'b1;
            e_mem_we = t_we && t_inr;
            if (e_mem_we) ref_mem[t_word] = t_wdata;
        end
        if (busy && cyc == g + 2) begin
            e_ack[tm]   = 1'b1;
            e_err[tm]   = !t_inr;
            e_rdata[tm] = (!t_we && t_inr) ? rd_ref(t_word) : 32'h0;
            pend[tm]    = 0;
            lk          = t_lock ? tm : -1;
            idle        = 0;
            busy        = 0;
        end else if (!busy) begin
            arbitrate();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_ack", {m1_ack, m0_ack}, 2'b00);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
        end else begin
            model_step();
            chk("ack0", m0_ack, e_ack[0]);
            chk("ack1", m1_ack, e_ack[1]);
            chk("mem_we", mem_we, e_mem_we);
            chk("rdata0", m0_rdata, e_rdata[0]);
            chk("rdata1", m1_rdata, e_rdata[1]);
            if (e_ack[0]) chk("err0", m0_err, e_err[0]);
            if (e_ack[1]) chk("err1", m1_err, e_err[1]);
            if (e_access) begin
                chk("mem_addr", mem_addr, t_addr);
                if (e_mem_we) chk("mem_wdata", mem_wdata, t_wdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_s[m] = 1'b1; we_s[m] = we; lock_s[m] = lock; addr_s[m] = addr; wdata_s[m] = wdata;
    endtask

    task automatic new_txn(input int m);
        if ($urandom_range(9) == 0)
            addr_s[m] = 32'h40000 + 32'($urandom_range(1023)) * 4 + 32'($urandom_range(3));
        else
            addr_s[m] = 32'($urandom_range(15)) * 4 + 32'($urandom_range(3));
        req_s[m]   = 1'b1;
        we_s[m]    = 1'($urandom_range(1));
        lock_s[m]  = ($urandom_range(3) == 0);
        wdata_s[m] = $urandom;
    endtask

    task automatic do_reset();
        req_s = 2'b00;
        rst_n = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        addr_s[0] = 32'h0; addr_s[1] = 32'h0; wdata_s[0] = 32'h0; wdata_s[1] = 32'h0;
        do_reset();

        // m0 write 0x7D0 <- 5, then m1 reads it back
        next_cycle(); set_m(0, 1'b1, 1'b0, 32'h7D0, 32'd5);
        next_cycle(); chk("t1_mem_we", mem_we, 1'b1); chk("t1_no_early_ack", m0_ack, 1'b0);
        next_cycle(); chk("t1_ack", m0_ack, 1'b1); chk("t1_mem500", mem[500], 32'd5);
        req_s[0] = 1'b0;
        next_cycle(); set_m(1, 1'b0, 1'b0, 32'h7D0, 32'h0);
        next_cycle(); chk("t2_mem_we", mem_we, 1'b0);
        next_cycle(); chk("t2_ack", m1_ack, 1'b1); chk("t2_rdata", m1_rdata, 32'd5);
        chk("t2_err", m1_err, 1'b0);
        req_s[1] = 1'b0;

        // m1 out-of-range write
        next_cycle(); set_m(1, 1'b1, 1'b0, 32'h40000, 32'hDEAD);
        next_cycle(); chk("t6_mem_we", mem_we, 1'b0);
        next_cycle(); chk("t6_ack", m1_ack, 1'b1); chk("t6_err", m1_err, 1'b1);
        chk("t6_rdata", m1_rdata, 32'h0);
        req_s[1] = 1'b0;

        // locked read-modify-write by m0 while m1 keeps requesting
        next_cycle(); set_m(0, 1'b0, 1'b1, 32'h10, 32'h0); set_m(1, 1'b1, 1'b0, 32'h20, 32'd7);
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            if (i < 8) chk("t4_m1_starved", m1_ack, 1'b0);
            if (i == 2) begin chk("t4_rd_ack", m0_ack, 1'b1); set_m(0, 1'b1, 1'b0, 32'h10, 32'd9); end
            if (i == 4) begin chk("t4_wr_we", mem_we, 1'b1); chk("t4_wr_addr", mem_addr, 32'h10); end
            if (i == 5) begin chk("t4_wr_ack", m0_ack, 1'b1); req_s[0] = 1'b0; end
            if (i == 8) begin chk("t4_m1_ack", m1_ack, 1'b1); req_s[1] = 1'b0; end
        end

        // lock left idle by m0 expires after LOCK_MAX idle cycles
        next_cycle(); set_m(0, 1'b0, 1'b1, 32'h30, 32'h0); set_m(1, 1'b1, 1'b0, 32'h34, 32'd3);
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            if (i < 9) chk("t5_m1_wait", m1_ack, 1'b0);
            if (i == 2) begin chk("t5_lock_ack", m0_ack, 1'b1); req_s[0] = 1'b0; end
            if (i == 8) begin chk("t5_we", mem_we, 1'b1); chk("t5_addr", mem_addr, 32'h34); end
            if (i == 9) begin chk("t5_m1_ack", m1_ack, 1'b1); req_s[1] = 1'b0; end
        end

        // reset during ACCESS aborts a write
        next_cycle(); set_m(0, 1'b1, 1'b0, 32'h44, 32'h55);
        next_cycle(); chk("t6r_we_before", mem_we, 1'b1);
        rst_n = 1'b0; req_s = 2'b00;
        #1 chk("t6r_we_dropped", mem_we, 1'b0);
        next_cycle(); chk("t6r_no_ack", m0_ack, 1'b0); chk("t6r_mem17", mem[17], 32'h0);
        rst_n = 1'b1;
        next_cycle(); next_cycle(); chk("t6r_no_late_ack", m0_ack, 1'b0);

        // both masters requesting continuously from reset alternate m0, m1, ...
        do_reset();
        set_m(0, 1'b0, 1'b0, 32'h7D0, 32'h0); set_m(1, 1'b0, 1'b0, 32'h7D0, 32'h0);
        for (int i = 1; i <= 18; i++) begin
            next_cycle();
            if (i % 3 == 2) begin
                chk("t3_ack0", m0_ack, ((i / 3) % 2) == 0);
                chk("t3_ack1", m1_ack, ((i / 3) % 2) == 1);
            end
        end
        req_s = 2'b00;
        repeat (2) next_cycle();

        // random traffic from both masters
        for (int k = 0; k < 2500; k++) begin
            next_cycle();
            for (int m = 0; m < 2; m++) begin
                if (e_ack[m]) begin
                    if ($urandom_range(3) == 0) new_txn(m);
                    else req_s[m] = 1'b0;
                end else if (req_s[m]) begin
                    if (pend[m]) begin
                        we_s[m] = 1'($urandom_range(1)); lock_s[m] = 1'($urandom_range(1));
                        addr_s[m] = $urandom; wdata_s[m] = $urandom;
                    end else if ($urandom_range(19) == 0) begin
                        req_s[m] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    new_txn(m);
                end
            end
        end
        req_s = 2'b00;
        repeat (6) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
